// File: rtl/vp_pkg.sv
// Shared defaults for the YCbCr skin detector: chroma skin window and coordinate width,
// plus the inclusive range test used by the classifier.
package vp_pkg;

    localparam logic [7:0] CB_MIN_DEF = 8'd77;
    localparam logic [7:0] CB_MAX_DEF = 8'd127;
    localparam logic [7:0] CR_MIN_DEF = 8'd133;
    localparam logic [7:0] CR_MAX_DEF = 8'd173;
    localparam int         CW_DEF     = 11;

    localparam logic [23:0] PIX_WHITE = 24'hFFFFFF;
    localparam logic [23:0] PIX_BLACK = 24'h000000;

    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vp_pos_cnt.sv
// Pixel coordinate tracker: saturating x/y counters driven by the data-enable and vsync
// edges of the input stream; x is the column of the pixel currently on the input.
module vp_pos_cnt
    import vp_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pre_vs,
    input  logic          pre_de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de_fall,
    output logic          vs_rise
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          r_de_d;
    logic          r_vs_d;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    assign de_fall = r_de_d & ~pre_de;
    assign vs_rise = pre_vs & ~r_vs_d;
    assign x       = r_x;
    assign y       = r_y;

    // Edge history and saturating coordinate counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_x    <= {CW{1'b0}};
            r_y    <= {CW{1'b0}};
        end else begin
            r_de_d <= pre_de;
            r_vs_d <= pre_vs;
            if (de_fall) begin
                r_x <= {CW{1'b0}};
            end else if (pre_de && (r_x != CNT_MAX)) begin
                r_x <= r_x + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                r_x <= r_x;
            end
            if (vs_rise) begin
                r_y <= {CW{1'b0}};
            end else if (de_fall && (r_y != CNT_MAX)) begin
                r_y <= r_y + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                r_y <= r_y;
            end
        end
    end

endmodule

// File: rtl/ycbcr_skin_box.sv
// YCbCr skin binarizer with per-frame bounding box and pixel count; two-cycle pixel
// pipeline, statistics published on each vsync rising edge.
module ycbcr_skin_box
    import vp_pkg::*;
#(
    parameter logic [7:0] CB_MIN = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX = CR_MAX_DEF,
    parameter int         CW     = CW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EN,
    input  logic            pre_vs,
    input  logic            pre_de,
    input  logic [7:0]      pre_y,
    input  logic [7:0]      pre_cb,
    input  logic [7:0]      pre_cr,
    output logic            post_vs,
    output logic            post_de,
    output logic [23:0]     post_data,
    output logic [CW-1:0]   box_xmin,
    output logic [CW-1:0]   box_xmax,
    output logic [CW-1:0]   box_ymin,
    output logic [CW-1:0]   box_ymax,
    output logic [2*CW-1:0] box_cnt,
    output logic            box_valid,
    output logic            box_hit
);

    logic [CW-1:0]   w_x;
    logic [CW-1:0]   w_y;
    logic            w_de_fall;
    logic            w_vs_rise;
    logic            w_skin;

    logic            r_vs1;
    logic            r_de1;
    logic            r_skin1;
    logic            r_vs2;
    logic            r_de2;
    logic [23:0]     r_data2;

    logic            r_armed;
    logic [CW-1:0]   r_xmin;
    logic [CW-1:0]   r_xmax;
    logic [CW-1:0]   r_ymin;
    logic [CW-1:0]   r_ymax;
    logic [2*CW-1:0] r_cnt;

    logic [CW-1:0]   r_box_xmin;
    logic [CW-1:0]   r_box_xmax;
    logic [CW-1:0]   r_box_ymin;
    logic [CW-1:0]   r_box_ymax;
    logic [2*CW-1:0] r_box_cnt;
    logic            r_box_valid;
    logic            r_box_hit;

    vp_pos_cnt #(.CW(CW)) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .pre_vs  (pre_vs),
        .pre_de  (pre_de),
        .x       (w_x),
        .y       (w_y),
        .de_fall (w_de_fall),
        .vs_rise (w_vs_rise)
    );

    assign w_skin = pre_de && in_range(pre_cb, CB_MIN, CB_MAX) && in_range(pre_cr, CR_MIN, CR_MAX);

    // Two-stage classify/binarize pipeline; data is blanked while vsync is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs1   <= 1'b0;
            r_de1   <= 1'b0;
            r_skin1 <= 1'b0;
            r_vs2   <= 1'b0;
            r_de2   <= 1'b0;
            r_data2 <= PIX_BLACK;
        end else begin
            r_vs1   <= pre_vs;
            r_de1   <= pre_de;
            r_skin1 <= w_skin & ~pre_vs;
            r_vs2   <= r_vs1;
            r_de2   <= r_de1;
            r_data2 <= (r_skin1 && !pre_vs) ? PIX_WHITE : PIX_BLACK;
        end
    end

    // Running frame statistics and publication on vsync rise; a frame counts only once
    // armed by a vsync rise seen with EN high, so partial frames never publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_xmin      <= {CW{1'b1}};
            r_xmax      <= {CW{1'b0}};
            r_ymin      <= {CW{1'b1}};
            r_ymax      <= {CW{1'b0}};
            r_cnt       <= {(2*CW){1'b0}};
            r_box_xmin  <= {CW{1'b0}};
            r_box_xmax  <= {CW{1'b0}};
            r_box_ymin  <= {CW{1'b0}};
            r_box_ymax  <= {CW{1'b0}};
            r_box_cnt   <= {(2*CW){1'b0}};
            r_box_valid <= 1'b0;
            r_box_hit   <= 1'b0;
        end else if (!EN) begin
            r_armed     <= 1'b0;
            r_box_valid <= 1'b0;
        end else if (w_vs_rise) begin
            if (r_armed) begin
                r_box_valid <= 1'b1;
                r_box_hit   <= (r_cnt != {(2*CW){1'b0}});
                r_box_cnt   <= r_cnt;
                if (r_cnt != {(2*CW){1'b0}}) begin
                    r_box_xmin <= r_xmin;
                    r_box_xmax <= r_xmax;
                    r_box_ymin <= r_ymin;
                    r_box_ymax <= r_ymax;
                end else begin
                    r_box_xmin <= r_box_xmin;
                    r_box_xmax <= r_box_xmax;
                    r_box_ymin <= r_box_ymin;
                    r_box_ymax <= r_box_ymax;
                end
            end else begin
                r_box_valid <= 1'b0;
            end
            r_armed <= 1'b1;
            r_xmin  <= {CW{1'b1}};
            r_xmax  <= {CW{1'b0}};
            r_ymin  <= {CW{1'b1}};
            r_ymax  <= {CW{1'b0}};
            r_cnt   <= {(2*CW){1'b0}};
        end else begin
            r_box_valid <= 1'b0;
            if (r_armed && w_skin && !pre_vs) begin
                r_xmin <= (w_x < r_xmin) ? w_x : r_xmin;
                r_xmax <= (w_x > r_xmax) ? w_x : r_xmax;
                r_ymin <= (w_y < r_ymin) ? w_y : r_ymin;
                r_ymax <= (w_y > r_ymax) ? w_y : r_ymax;
                r_cnt  <= r_cnt + {{(2*CW-1){1'b0}}, 1'b1};
            end else begin
                r_cnt  <= r_cnt;
            end
        end
    end

    assign post_vs   = EN ? r_vs2   : pre_vs;
    assign post_de   = EN ? r_de2   : pre_de;
    assign post_data = EN ? r_data2 : {pre_y, pre_cb, pre_cr};
    assign box_xmin  = r_box_xmin;
    assign box_xmax  = r_box_xmax;
    assign box_ymin  = r_box_ymin;
    assign box_ymax  = r_box_ymax;
    assign box_cnt   = r_box_cnt;
    assign box_hit   = r_box_hit;
    assign box_valid = r_box_valid & EN;

endmodule

// File: tb/tb_ycbcr_skin_box.sv
// Directed bench for ycbcr_skin_box: pixel classification, box statistics, bypass and
// reset behaviour against hand-computed expectations.
module tb_ycbcr_skin_box;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN = 1'b1;
    logic        pre_vs = 1'b0;
    logic        pre_de = 1'b0;
    logic [7:0]  pre_y = 8'd0;
    logic [7:0]  pre_cb = 8'd0;
    logic [7:0]  pre_cr = 8'd0;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;
    logic [10:0] box_xmin;
    logic [10:0] box_xmax;
    logic [10:0] box_ymin;
    logic [10:0] box_ymax;
    logic [21:0] box_cnt;
    logic        box_valid;
    logic        box_hit;

    int n_checks = 0;
    int n_errors = 0;
    int vcnt = 0;
    int v0;

    ycbcr_skin_box dut (
        .clk(clk), .rst_n(rst_n), .EN(EN),
        .pre_vs(pre_vs), .pre_de(pre_de),
        .pre_y(pre_y), .pre_cb(pre_cb), .pre_cr(pre_cr),
        .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
        .box_xmin(box_xmin), .box_xmax(box_xmax),
        .box_ymin(box_ymin), .box_ymax(box_ymax),
        .box_cnt(box_cnt), .box_valid(box_valid), .box_hit(box_hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (box_valid) vcnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pix(input logic de, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        pre_de = de;
        pre_y  = y;
        pre_cb = cb;
        pre_cr = cr;
    endtask

    // One-pixel pipeline check: drive, then inspect post_data two edges later.
    task automatic pix_test(input string tag, input logic [7:0] cb, input logic [7:0] cr, input logic [23:0] exp);
        drive_pix(1'b1, 8'd128, cb, cr);
        tick();
        drive_pix(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        chk(tag, 32'(post_data), 32'(exp));
    endtask

    task automatic send_row(input int w, input int sa, input int sb);
        for (int x = 0; x < w; x++) begin
            if (sa == -2 || x == sa || x == sb) drive_pix(1'b1, 8'd128, 8'd100, 8'd150);
            else drive_pix(1'b1, 8'd128, 8'd128, 8'd150);
            tick();
        end
        drive_pix(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
    endtask

    task automatic send_frame(input int w, input int h, input int x0, input int y0, input int x1, input int y1);
        for (int r = 0; r < h; r++) begin
            send_row(w, (r == y0) ? x0 : -1, (r == y1) ? x1 : -1);
        end
    endtask

    // Vsync pulse; optionally drives a skin pixel with de while vs is high.
    task automatic vs_pulse(input logic dirty);
        pre_vs = 1'b1;
        if (dirty) drive_pix(1'b1, 8'd128, 8'd100, 8'd150);
        tick();
        drive_pix(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        if (dirty) chk("vs_blank", 32'(post_data), 32'h0);
        pre_vs = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_data", 32'(post_data), 32'h0);
        chk("rst_valid", 32'(box_valid), 32'h0);
        chk("rst_hit", 32'(box_hit), 32'h0);
        chk("rst_cnt", 32'(box_cnt), 32'h0);
        chk("rst_xmin", 32'(box_xmin), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic classification and latency
        drive_pix(1'b1, 8'd128, 8'd100, 8'd150);
        tick();
        drive_pix(1'b0, 8'd0, 8'd0, 8'd0);
        chk("lat1_data", 32'(post_data), 32'h0);
        tick();
        chk("skin_data", 32'(post_data), 32'hFFFFFF);
        chk("skin_de", 32'(post_de), 32'h1);
        pix_test("nonskin", 8'd128, 8'd150, 24'h000000);
        pix_test("cb77", 8'd77, 8'd150, 24'hFFFFFF);
        pix_test("cb127", 8'd127, 8'd150, 24'hFFFFFF);
        pix_test("cr133", 8'd100, 8'd133, 24'hFFFFFF);
        pix_test("cr173", 8'd100, 8'd173, 24'hFFFFFF);
        pix_test("cb76", 8'd76, 8'd150, 24'h000000);
        pix_test("cb128", 8'd128, 8'd150, 24'h000000);
        pix_test("cr132", 8'd100, 8'd132, 24'h000000);
        pix_test("cr174", 8'd100, 8'd174, 24'h000000);
        drive_pix(1'b0, 8'd128, 8'd100, 8'd150);
        tick();
        tick();
        chk("de0_data", 32'(post_data), 32'h0);
        drive_pix(1'b0, 8'd0, 8'd0, 8'd0);

        // Frame with two skin pixels
        v0 = vcnt;
        vs_pulse(1'b0);
        chk("arm_novalid", 32'(vcnt - v0), 32'h0);
        send_frame(16, 8, 3, 2, 10, 5);
        vs_pulse(1'b0);
        chk("a_valid", 32'(vcnt - v0), 32'h1);
        chk("a_xmin", 32'(box_xmin), 32'd3);
        chk("a_xmax", 32'(box_xmax), 32'd10);
        chk("a_ymin", 32'(box_ymin), 32'd2);
        chk("a_ymax", 32'(box_ymax), 32'd5);
        chk("a_cnt", 32'(box_cnt), 32'd2);
        chk("a_hit", 32'(box_hit), 32'h1);

        // Frame without skin
        send_frame(16, 8, -1, -1, -1, -1);
        vs_pulse(1'b1);
        chk("b_valid", 32'(vcnt - v0), 32'h2);
        chk("b_hit", 32'(box_hit), 32'h0);
        chk("b_cnt", 32'(box_cnt), 32'h0);
        chk("b_xmin", 32'(box_xmin), 32'd3);
        chk("b_xmax", 32'(box_xmax), 32'd10);
        chk("b_ymin", 32'(box_ymin), 32'd2);
        chk("b_ymax", 32'(box_ymax), 32'd5);

        // Bypass
        EN = 1'b0;
        drive_pix(1'b1, 8'd10, 8'd20, 8'd30);
        #1;
        chk("byp_data", 32'(post_data), 32'h0A141E);
        chk("byp_de", 32'(post_de), 32'h1);
        chk("byp_vs", 32'(post_vs), 32'h0);
        drive_pix(1'b0, 8'd0, 8'd0, 8'd0);
        v0 = vcnt;
        send_frame(16, 4, 5, 1, -1, -1);
        vs_pulse(1'b0);
        send_frame(16, 4, 6, 2, -1, -1);
        vs_pulse(1'b0);
        chk("byp_novalid", 32'(vcnt - v0), 32'h0);
        chk("byp_frozen", 32'(box_xmin), 32'd3);
        send_row(16, 2, -1);
        EN = 1'b1;
        send_row(16, 4, -1);
        vs_pulse(1'b0);
        chk("en_partial", 32'(vcnt - v0), 32'h0);
        send_frame(16, 8, 1, 1, -1, -1);
        vs_pulse(1'b0);
        chk("en_valid", 32'(vcnt - v0), 32'h1);
        chk("en_xmin", 32'(box_xmin), 32'd1);
        chk("en_ymax", 32'(box_ymax), 32'd1);
        chk("en_cnt", 32'(box_cnt), 32'd1);

        // Reset mid-frame
        send_row(16, -1, -1);
        for (int i = 0; i < 4; i++) begin
            drive_pix(1'b1, 8'd128, 8'd100, 8'd150);
            tick();
        end
        chk("pre_rst_data", 32'(post_data), 32'hFFFFFF);
        rst_n = 1'b0;
        #1;
        chk("mrst_data", 32'(post_data), 32'h0);
        chk("mrst_de", 32'(post_de), 32'h0);
        chk("mrst_xmax", 32'(box_xmax), 32'h0);
        chk("mrst_cnt", 32'(box_cnt), 32'h0);
        chk("mrst_hit", 32'(box_hit), 32'h0);
        tick();
        rst_n = 1'b1;
        v0 = vcnt;
        send_row(16, 2, -1);
        vs_pulse(1'b0);
        chk("mrst_first_vs", 32'(vcnt - v0), 32'h0);
        send_frame(16, 8, 0, 0, -1, -1);
        vs_pulse(1'b0);
        chk("mrst_second_vs", 32'(vcnt - v0), 32'h1);
        chk("mrst_box_xmax", 32'(box_xmax), 32'd0);
        chk("mrst_box_cnt", 32'(box_cnt), 32'd1);
        chk("mrst_box_hit", 32'(box_hit), 32'h1);

        // x saturation over a long all-skin line
        send_row(2050, -2, -1);
        vs_pulse(1'b0);
        chk("sat_valid", 32'(vcnt - v0), 32'h2);
        chk("sat_xmax", 32'(box_xmax), 32'd2047);
        chk("sat_xmin", 32'(box_xmin), 32'd0);
        chk("sat_ymax", 32'(box_ymax), 32'd0);
        chk("sat_cnt", 32'(box_cnt), 32'd2050);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ycbcr_skin_box.md
YCBCR_SKIN_BOX -- requirements
Module: ycbcr_skin_box

Interface
REQ-001 SHALL have parameter CB_MIN, default 8'd77, meaning the inclusive lower Cb skin bound.
REQ-002 SHALL have parameter CB_MAX, default 8'd127, meaning the inclusive upper Cb skin bound.
REQ-003 SHALL have parameter CR_MIN, default 8'd133, meaning the inclusive lower Cr skin bound.
REQ-004 SHALL have parameter CR_MAX, default 8'd173, meaning the inclusive upper Cr skin bound.
REQ-005 SHALL have parameter CW, default 11, meaning the coordinate counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single module clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port EN, input, 1 bit: processing enable; 0 = bypass.
REQ-009 SHALL have ports pre_vs, pre_de, input, 1 bit each: active-high vsync and data-enable of the input stream.
REQ-010 SHALL have ports pre_y, pre_cb, pre_cr, input, 8 bits each: input YCbCr pixel.
REQ-011 SHALL have ports post_vs, post_de, output, 1 bit each: delayed syncs.
REQ-012 SHALL have port post_data, output, 24 bits: binarized pixel, 24'hFFFFFF for skin and 24'h000000 otherwise.
REQ-013 SHALL have ports box_xmin, box_xmax, box_ymin, box_ymax, output, CW bits each: skin bounding box of the last completed frame.
REQ-014 SHALL have port box_cnt, output, 2*CW bits: skin pixel count of the last completed frame.
REQ-015 SHALL have port box_valid, output, 1 bit: one-cycle pulse when the box outputs update.
REQ-016 SHALL have port box_hit, output, 1 bit: last completed frame contained at least one skin pixel.

Function
REQ-017 SHALL flag skin in stage 1 iff CB_MIN<=pre_cb<=CB_MAX and CR_MIN<=pre_cr<=CR_MAX, with the flag qualified by pre_de.
REQ-018 SHALL register the flag into post_data in stage 2, for a fixed 2-cycle latency with post_vs/post_de delayed identically.
REQ-019 SHALL force the pipeline data registers to 0 while pre_vs=1.
REQ-020 SHALL maintain x_cnt: +1 per pre_de=1 cycle, cleared on the pre_de falling edge; the current pixel x equals x_cnt before increment.
REQ-021 SHALL maintain y_cnt: +1 on each pre_de falling edge, cleared on the pre_vs rising edge.
REQ-022 SHALL saturate x_cnt and y_cnt at 2^CW-1, with no wrap.
REQ-023 SHALL update the running min/max/count per skin pixel, initialised to min=all-ones, max=0, count=0 at each pre_vs rising edge.
REQ-024 SHALL, on the pre_vs rising edge, latch the running values into the box outputs, set box_hit=(count!=0), and pulse box_valid for exactly one cycle.
REQ-025 SHALL, in the same cycle as REQ-024, have the latch use the pre-clear values and re-initialise the running registers.
REQ-026 SHALL leave box outputs unchanged when box_hit=0, except box_cnt=0.
REQ-027 SHALL, when EN=0, drive post_vs=pre_vs, post_de=pre_de and post_data={pre_y,pre_cb,pre_cr} combinationally, freeze statistics, and hold box_valid at 0.
REQ-028 SHALL resume statistics only from the next pre_vs rising edge after EN rises, with no box_valid for the partial frame.

Reset
REQ-029 SHALL, on rst_n=0, clear all pipeline, counter and running registers; box_* outputs SHALL be 0, box_valid=0, box_hit=0, post_data=0, and delayed syncs 0.
REQ-030 SHALL, on reset mid-frame, produce no box_valid until the second pre_vs rising edge after release.

Structure
REQ-031 SHALL hold the default thresholds and the CW default in shared package vp_pkg.
REQ-032 SHALL implement the coordinate/edge logic as sub-module vp_pos_cnt (outputs x, y, de_fall, vs_rise).

Verification
REQ-033 SHALL cover: (y,cb,cr)=(128,100,150) with de=1 -> post_data=24'hFFFFFF two cycles later; (128,128,150) -> 24'h000000.
REQ-034 SHALL cover: a 16x8 frame with skin at (3,2) and (10,5) only, then vs rise -> box=(3,10,2,5), box_cnt=2, box_hit=1, one box_valid pulse.
REQ-035 SHALL cover: a frame with no skin -> box_hit=0, box_cnt=0, previous box coordinates retained.
REQ-036 SHALL cover: EN=0 with input (10,20,30) -> post_data=24'h0A141E the same cycle, box_valid never asserted.
REQ-037 SHALL cover: rst_n asserted mid-frame -> all outputs 0 immediately, first box_valid at the second vs rise.
REQ-038 SHALL cover: boundary values cb=77/127 and cr=133/173 -> skin; cb=76/128 -> not skin.
